ac_link_serializer: RTL and testbench

Serial back end of the AC'97 output path. It takes the parallel slot words built by `slot_fsm` (tag slot 0, command slots 1–2, PCM slots 3–4), latches them once per frame and shifts a 256-bit AC-link frame out on `sdata_out` with the matching `sync` pulse. It also raises `frame_req` once per frame so the upstream waveform/slot logic can present the next sample.

---
 rtl/ac_link_pkg.sv | 28 ++
 rtl/ac_link_shifter.sv | 36 +++
 rtl/ac_link_serializer.sv | 134 +++++++++++++
 tb/tb_ac_link_serializer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ac_link_pkg.sv
// Shared constants, state encoding and load-vector packing for the AC-link serializer.
package ac_link_pkg;

   localparam int FRAME_BITS = 256;
   localparam int TAG_BITS   = 16;
   localparam int SLOT_BITS  = 20;
   localparam int SYNC_BITS  = 16;
   localparam int LOAD_BITS  = 96;
   localparam int K_W        = $clog2(FRAME_BITS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      RUN  = 2'd2
   } state_e;

   // Frame data order: tag first, then slots 1..4, each MSB first.
   function automatic logic [LOAD_BITS-1:0] build_load_vec(
      input logic [TAG_BITS-1:0]  tag,
      input logic [SLOT_BITS-1:0] s1,
      input logic [SLOT_BITS-1:0] s2,
      input logic [SLOT_BITS-1:0] s3,
      input logic [SLOT_BITS-1:0] s4
   );
      return {tag, s1, s2, s3, s4};
   endfunction

endpackage

// File: rtl/ac_link_shifter.sv
// 96-bit parallel-load shift-left register with zero fill; exposes its MSB.
module ac_link_shifter
   import ac_link_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [LOAD_BITS-1:0] load_vec,
   output logic                 msb
);

   logic [LOAD_BITS-1:0] shift_q;
   logic [LOAD_BITS-1:0] shift_d;

   // next shift-register contents: load a new frame or shift in a zero
   always_comb begin
      shift_d = shift_q;
      if (load) begin
         shift_d = load_vec;
      end else begin
         shift_d = {shift_q[LOAD_BITS-2:0], 1'b0};
      end
   end

   // shift-register state with synchronous clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_q <= {LOAD_BITS{1'b0}};
      end else begin
         shift_q <= shift_d;
      end
   end

   assign msb = shift_q[LOAD_BITS-1];

endmodule

// File: rtl/ac_link_serializer.sv
// AC-link frame serializer: frame FSM, bit counter and registered SYNC/data outputs.
// Optional AC_LINK_READY_GATE_EN adds codec_ready gating of start and continue.
module ac_link_serializer
   import ac_link_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
`ifdef AC_LINK_READY_GATE_EN
   input  logic                 codec_ready,
`endif
   input  logic [SLOT_BITS-1:0] slot0_in,
   input  logic [SLOT_BITS-1:0] slot1_in,
   input  logic [SLOT_BITS-1:0] slot2_in,
   input  logic [SLOT_BITS-1:0] slot3_in,
   input  logic [SLOT_BITS-1:0] slot4_in,
   output logic                 sync,
   output logic                 sdata_out,
   output logic                 frame_req,
   output logic                 busy
);

   localparam logic [K_W-1:0] K_ZERO      = K_W'(0);
   localparam logic [K_W-1:0] K_ONE       = K_W'(1);
   localparam logic [K_W-1:0] LAST_K      = K_W'(FRAME_BITS - 1);
   localparam logic [K_W-1:0] STOP_K      = K_W'(FRAME_BITS - 2);
   localparam logic [K_W-1:0] SYNC_LAST_K = K_W'(SYNC_BITS - 2);

   state_e               state_q, state_d;
   logic [K_W-1:0]       k_q, k_d;
   logic                 sync_q, sync_d;
   logic                 frame_req_q, frame_req_d;
   logic                 busy_q, busy_d;
   logic                 load_s;
   logic                 go_s;
   logic [LOAD_BITS-1:0] load_vec_s;
   logic [SLOT_BITS-TAG_BITS-1:0] unused_tag_hi_s;

`ifdef AC_LINK_READY_GATE_EN
   assign go_s = enable & codec_ready;
`else
   assign go_s = enable;
`endif

   assign unused_tag_hi_s = slot0_in[SLOT_BITS-1:TAG_BITS];
   assign load_vec_s = build_load_vec(slot0_in[TAG_BITS-1:0], slot1_in, slot2_in,
                                      slot3_in, slot4_in);

   // frame sequencing: start via PRE, continue/stop decided at the end of k=254
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      load_s  = 1'b0;
      case (state_q)
         IDLE: begin
            k_d = K_ZERO;
            if (go_s) begin
               state_d = PRE;
            end else begin
               state_d = IDLE;
            end
         end
         PRE: begin
            state_d = RUN;
            k_d     = K_ZERO;
            load_s  = 1'b1;
         end
         RUN: begin
            if ((k_q == STOP_K) && !go_s) begin
               state_d = IDLE;
               k_d     = K_ZERO;
            end else begin
               k_d    = k_q + K_ONE;
               load_s = (k_q == LAST_K);
            end
         end
         default: begin
            state_d = IDLE;
            k_d     = K_ZERO;
         end
      endcase
   end

   // outputs are decoded from the next state so they appear registered with it
   always_comb begin
      sync_d      = 1'b0;
      frame_req_d = 1'b0;
      busy_d      = (state_d != IDLE);
      case (state_d)
         PRE: begin
            sync_d      = 1'b1;
            frame_req_d = 1'b1;
         end
         RUN: begin
            sync_d      = (k_d == LAST_K) || (k_d <= SYNC_LAST_K);
            frame_req_d = (k_d == LAST_K);
         end
         default: begin
            sync_d      = 1'b0;
            frame_req_d = 1'b0;
         end
      endcase
   end

   // state, counter and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= K_ZERO;
         sync_q      <= 1'b0;
         frame_req_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         sync_q      <= sync_d;
         frame_req_q <= frame_req_d;
         busy_q      <= busy_d;
      end
   end

   ac_link_shifter u_shifter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_s),
      .load_vec (load_vec_s),
      .msb      (sdata_out)
   );

   assign sync      = sync_q;
   assign frame_req = frame_req_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_ac_link_serializer.sv
// Directed, table-driven bench for ac_link_serializer (ready-gate sequence runs
// only when AC_LINK_READY_GATE_EN is defined).
module tb_ac_link_serializer;

   typedef struct {
      logic [19:0] s0, s1, s2, s3, s4;
      logic [95:0] exp;
      bit          chg;
      logic [19:0] chg_s3;
   } frame_vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
`ifdef AC_LINK_READY_GATE_EN
   logic        codec_ready;
`endif
   logic [19:0] slot0_in, slot1_in, slot2_in, slot3_in, slot4_in;
   logic        sync, sdata_out, frame_req, busy;

   int checks = 0;
   int errors = 0;
   frame_vec_t tbl [3];
   logic [95:0] zero_vec;

   ac_link_serializer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
`ifdef AC_LINK_READY_GATE_EN
      .codec_ready (codec_ready),
`endif
      .slot0_in    (slot0_in),
      .slot1_in    (slot1_in),
      .slot2_in    (slot2_in),
      .slot3_in    (slot3_in),
      .slot4_in    (slot4_in),
      .sync        (sync),
      .sdata_out   (sdata_out),
      .frame_req   (frame_req),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int k, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s k=%0d got=%b want=%b", name, k, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int k,
                          input logic e_sync, input logic e_sd,
                          input logic e_fr, input logic e_busy);
      chk({tag, "_sync"}, k, sync, e_sync);
      chk({tag, "_sdata"}, k, sdata_out, e_sd);
      chk({tag, "_frame_req"}, k, frame_req, e_fr);
      chk({tag, "_busy"}, k, busy, e_busy);
   endtask

   function automatic logic exp_bit(input logic [95:0] v, input int k);
      return (k < 96) ? v[95-k] : 1'b0;
   endfunction

   // checks one running-frame cycle at bit index k against a hand-computed vector
   task automatic check_k(input string tag, input logic [95:0] v, input int k);
      chk_all(tag, k, (k < 15) || (k == 255), exp_bit(v, k), (k == 255), 1'b1);
   endtask

   task automatic apply(input int i);
      slot0_in = tbl[i].s0;
      slot1_in = tbl[i].s1;
      slot2_in = tbl[i].s2;
      slot3_in = tbl[i].s3;
      slot4_in = tbl[i].s4;
   endtask

   initial begin
      tbl[0] = '{s0: 20'h0F800, s1: 20'h04000, s2: 20'h00000, s3: 20'hABCDE, s4: 20'hABCDE,
                 exp: 96'hF800_04000_00000_ABCDE_ABCDE, chg: 1'b1, chg_s3: 20'h12345};
      tbl[1] = '{s0: 20'hFA5A5, s1: 20'hFFFFF, s2: 20'h80001, s3: 20'h12345, s4: 20'h00001,
                 exp: 96'hA5A5_FFFFF_80001_12345_00001, chg: 1'b0, chg_s3: 20'h00000};
      tbl[2] = '{s0: 20'h00000, s1: 20'h00000, s2: 20'h00000, s3: 20'h00000, s4: 20'h00000,
                 exp: 96'h0, chg: 1'b0, chg_s3: 20'h00000};
      zero_vec = 96'h0;

      rst_n  = 1'b0;
      enable = 1'b1;
`ifdef AC_LINK_READY_GATE_EN
      codec_ready = 1'b1;
`endif
      apply(0);

      // reset held with enable high
      repeat (3) begin
         step();
         chk_all("reset", -1, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // start: PRE then back-to-back frames from the table
      rst_n = 1'b1;
      step();
      chk_all("pre", -1, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 256; k++) begin
            step();
            check_k($sformatf("frame%0d", r), tbl[r].exp, k);
            if (tbl[r].chg && k == 40) slot3_in = tbl[r].chg_s3;
            if (k == 255 && r < 2) apply(r + 1);
         end
      end

      // stop: enable dropped mid-frame, frame completes through k=254
      for (int k = 0; k < 255; k++) begin
         step();
         check_k("stopframe", zero_vec, k);
         if (k == 100) enable = 1'b0;
      end
      step();
      chk_all("stop_idle", 255, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) begin
         step();
         chk_all("idle", -1, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // restart after idle
      enable = 1'b1;
      apply(0);
      step();
      chk_all("restart_pre", -1, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 256; k++) begin
         step();
         check_k("restart", tbl[0].exp, k);
      end

      // reset mid-frame at k=60
      for (int k = 0; k <= 60; k++) begin
         step();
         check_k("prereset", tbl[0].exp, k);
      end
      rst_n = 1'b0;
      step();
      chk_all("midreset", -1, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step();
      chk_all("postreset_pre", -1, 1'b1, 1'b0, 1'b1, 1'b1);
      step();
      check_k("postreset", tbl[0].exp, 0);

`ifdef AC_LINK_READY_GATE_EN
      rst_n = 1'b0;
      step();
      chk_all("gate_reset", -1, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      codec_ready = 1'b0;
      repeat (20) begin
         step();
         chk_all("gate_wait", -1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      codec_ready = 1'b1;
      step();
      chk_all("gate_pre", -1, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 255; k++) begin
         step();
         check_k("gate_frame", tbl[0].exp, k);
         if (k == 200) codec_ready = 1'b0;
      end
      step();
      chk_all("gate_idle", 255, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
